// File: rtl/serial_byte_receiver.sv
// Serial-to-parallel receiver for MSB-first or LSB-first shift-register streams with a valid/ready word port.
// Optional even-parity bit per frame when SR_RX_PARITY_EN is defined (adds PAR state and parity_err port).
module serial_byte_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             start,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
`ifdef SR_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SR_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic               frame_lsb;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shifted;
  logic               lsb_eff;
  logic               last_data;
  logic               frame_done;
  logic [WIDTH-1:0]   done_word;
  logic               accept;

  // MSB-first sources push into the LSB; LSB-first sources push into the MSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic b, input logic lsb);
    if (lsb) return {b, cur[WIDTH-1:1]};
    else     return {cur[WIDTH-2:0], b};
  endfunction

  always_comb begin
    lsb_eff    = (start || state == IDLE) ? lsb_first : frame_lsb;
    shifted    = shift_in(shreg, serial_in, lsb_eff);
    last_data  = (state == RECV) && (bit_cnt == CNT_W'(WIDTH - 1));
    frame_done = 1'b0;
    done_word  = shifted;
`ifdef SR_RX_PARITY_EN
    frame_done = in_valid && !start && (state == PAR);
    done_word  = shreg;
`else
    frame_done = in_valid && !start && last_data;
`endif
    accept = !out_valid || out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      frame_lsb    <= 1'b0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
`ifdef SR_RX_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
`ifdef SR_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // A start with in_valid always opens a fresh frame, silently abandoning any partial one.
      if (in_valid) begin
        if (start) begin
          shreg     <= shifted;
          bit_cnt   <= CNT_W'(1);
          frame_lsb <= lsb_first;
          state     <= RECV;
          busy      <= 1'b1;
        end else begin
          case (state)
            RECV: begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (last_data) begin
`ifdef SR_RX_PARITY_EN
                state <= PAR;
`else
                state   <= IDLE;
                busy    <= 1'b0;
                bit_cnt <= '0;
`endif
              end
            end
`ifdef SR_RX_PARITY_EN
            PAR: begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_cnt <= '0;
            end
`endif
            default: ;
          endcase
        end
      end

      // Output port: load when free or being drained this edge, otherwise drop and flag.
      if (frame_done) begin
        if (accept) begin
          parallel_out <= done_word;
          out_valid    <= 1'b1;
`ifdef SR_RX_PARITY_EN
          parity_err   <= ^shreg ^ serial_in;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed self-checking bench for serial_byte_receiver (WIDTH=8), parity checks under SR_RX_PARITY_EN.
module tb_serial_byte_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       start = 1'b0;
  logic       lsb_first = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] parallel_out;
  logic       out_valid;
  logic       overrun;
  logic       busy;
`ifdef SR_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad = 0;

  serial_byte_receiver #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
    .start(start), .lsb_first(lsb_first), .parallel_out(parallel_out),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
`ifdef SR_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    serial_in = b;
    in_valid  = 1'b1;
    start     = st;
    tick();
    in_valid  = 1'b0;
    start     = 1'b0;
  endtask

  task automatic send_parity(input logic [7:0] v, input logic flip);
`ifdef SR_RX_PARITY_EN
    send_bit((^v) ^ flip, 1'b0);
`endif
  endtask

  task automatic send_frame(input logic [7:0] v, input logic lsb);
    lsb_first = lsb;
    for (int i = 0; i < 8; i++)
      send_bit(lsb ? v[i] : v[7-i], i == 0);
    send_parity(v, 1'b0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (parallel_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", parallel_out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_msb_first();
    logic [7:0] v;
    v = 8'hAA;
    lsb_first = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(v[7-i], i == 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL msb_busy got=%b want=1", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL msb_early_valid got=%b want=0", out_valid); end
    send_bit(v[0], 1'b0);
    send_parity(v, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b want=1", out_valid); end
    total++; if (parallel_out !== 8'hAA) begin bad++; $display("FAIL msb_data got=%h want=aa", parallel_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL msb_idle got=%b want=0", busy); end
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL msb_consumed got=%b want=0", out_valid); end
  endtask

  task automatic test_lsb_first();
    send_frame(8'h99, 1'b1);
    total++; if (parallel_out !== 8'h99 || out_valid !== 1'b1) begin bad++; $display("FAIL lsb_99 got=%h/%b want=99/1", parallel_out, out_valid); end
    consume();
    send_frame(8'hF0, 1'b1);
    total++; if (parallel_out !== 8'hF0 || out_valid !== 1'b1) begin bad++; $display("FAIL lsb_f0 got=%h/%b want=f0/1", parallel_out, out_valid); end
    consume();
  endtask

  task automatic test_stall_abort();
    logic [7:0] v;
    v = 8'hAA;
    lsb_first = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(v[7-i], i == 0);
    tick(); tick(); tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", busy); end
    for (int i = 4; i < 8; i++) send_bit(v[7-i], 1'b0);
    send_parity(v, 1'b0);
    total++; if (parallel_out !== 8'hAA || out_valid !== 1'b1) begin bad++; $display("FAIL stall_data got=%h/%b want=aa/1", parallel_out, out_valid); end
    consume();
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    send_frame(8'h5A, 1'b0);
    total++; if (parallel_out !== 8'h5A || out_valid !== 1'b1) begin bad++; $display("FAIL abort_data got=%h/%b want=5a/1", parallel_out, out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL abort_overrun got=%b want=0", overrun); end
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_single got=%b want=0", out_valid); end
  endtask

  task automatic test_overrun();
    send_frame(8'h0F, 1'b0);
    send_frame(8'hF0, 1'b0);
    total++; if (parallel_out !== 8'h0F) begin bad++; $display("FAIL ovr_keep got=%h want=0f", parallel_out); end
    total++; if (overrun !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b/%b want=1/1", overrun, out_valid); end
    consume();
    total++; if (out_valid !== 1'b0 || overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b/%b want=0/1", out_valid, overrun); end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h11, 1'b0);
    lsb_first = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL rstmid got=%b/%b/%b want=0/0/0", busy, out_valid, overrun); end
    send_frame(8'h3C, 1'b0);
    total++; if (parallel_out !== 8'h3C || out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_next got=%h/%b want=3c/1", parallel_out, out_valid); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    send_frame(8'hC3, 1'b0);
    total++; if (parallel_out !== 8'hC3) begin bad++; $display("FAIL b2b_first got=%h want=c3", parallel_out); end
    v = 8'h81;
    lsb_first = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(v[7-i], i == 0);
`ifdef SR_RX_PARITY_EN
    send_bit(v[0], 1'b0);
    out_ready = 1'b1;
    send_parity(v, 1'b0);
`else
    out_ready = 1'b1;
    send_bit(v[0], 1'b0);
`endif
    out_ready = 1'b0;
    total++; if (parallel_out !== 8'h81 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_swap got=%h/%b want=81/1", parallel_out, out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
    consume();
  endtask

`ifdef SR_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'hAA, 1'b0);
    total++; if (parity_err !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL par_ok got=%b/%b want=0/1", parity_err, out_valid); end
    consume();
    lsb_first = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(8'hAB >> (7 - i), i == 0);
    send_bit(1'b0, 1'b0);
    total++; if (parity_err !== 1'b1 || parallel_out !== 8'hAB) begin bad++; $display("FAIL par_err got=%b/%h want=1/ab", parity_err, parallel_out); end
    consume();
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clear got=%b want=0", parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall_abort();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
`ifdef SR_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
